line_window_3x3: RTL and testbench

- Streaming 3x3 window generator at the front of the bilateral filter accelerator.
- Takes one raster-order pixel per accepted cycle.
- Buffers the two previous image rows in line memories and emits the full 3x3 neighbourhood with its centre coordinates.
- Feeds the bilateral kernel datapath. Downstream delay-matching pipeline_shift stages align the centre pixel and coordinates with the kernel's weight arithmetic.

---
 rtl/line_window_3x3.sv | 117 +++++++++++
 tb/tb_line_window_3x3.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/line_window_3x3.sv
// Streaming 3x3 neighbourhood generator for the bilateral filter front end.
// Two line memories plus a 3x3 register window; one window per interior pixel.
module line_window_3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    localparam int XW = $clog2(IMG_WIDTH),
    localparam int YW = $clog2(IMG_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    output logic [9*DATA_WIDTH-1:0] out_window,
    output logic [XW-1:0]           out_x,
    output logic [YW-1:0]           out_y
);

    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          accept;
    logic          col_last;
    logic          row_last;
    logic          interior;

    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb2 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    logic [DATA_WIDTH-1:0] win [3][3];

    // Resolve the pixel position: start-of-frame overrides the counters.
    always_comb begin
        accept   = in_valid && !rst;
        cx       = in_sof ? '0 : col;
        cy       = in_sof ? '0 : row;
        col_last = (cx == XW'(IMG_WIDTH - 1));
        row_last = (cy == YW'(IMG_HEIGHT - 1));
        interior = (cx >= XW'(2)) && (cy >= YW'(2));
        rd1      = lb1[cx];
        rd2      = lb2[cx];
    end

    // Raster position counters, advanced once per accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : cy + YW'(1);
            end else begin
                col <= cx + XW'(1);
                row <= cy;
            end
        end
    end

    // Line memories: the old row-1 value moves down to row-2 (read before write).
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[cx] <= lb1[cx];
            lb1[cx] <= in_data;
        end
    end

    // Window shifts left and takes the new column on each accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= rd2;
            win[1][2] <= rd1;
            win[2][2] <= in_data;
        end
    end

    // Valid pulse and centre coordinates track the window update.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            out_valid <= accept && interior;
            if (accept) begin
                out_x <= cx - XW'(1);
                out_y <= cy - YW'(1);
            end
        end
    end

    // Flatten the window: element r*3+c, top-left at the LSBs.
    always_comb begin
        out_window = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                out_window[(r*3+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
            end
        end
    end

endmodule

// File: tb/tb_line_window_3x3.sv
// Self-checking bench for line_window_3x3 on a 5x4 image.
// Reference keeps a frame store and cuts each 3x3 neighbourhood from it.
module tb_line_window_3x3;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic [9*DW-1:0] out_window;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit plain  = 1'b0;

    // reference model state
    int mx = 0;
    int my = 0;
    logic [DW-1:0] img [H][W];

    line_window_3x3 #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_window(out_window),
        .out_x     (out_x),
        .out_y     (out_y)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input logic v, input logic s,
                        input logic [DW-1:0] d, input logic r);
        logic          exp_v;
        logic [9*DW-1:0] exp_w;
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        exp_v = 1'b0;
        exp_w = '0;
        ex    = '0;
        ey    = '0;
        rst      = r;
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
        if (r) begin
            mx = 0;
            my = 0;
        end else if (v) begin
            if (s) begin
                mx = 0;
                my = 0;
            end
            img[my][mx] = d;
            if (mx >= 2 && my >= 2) begin
                exp_v = 1'b1;
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        exp_w[(rr*3+cc)*DW +: DW] = img[my-2+rr][mx-2+cc];
                ex = XW'(mx - 1);
                ey = YW'(my - 1);
            end
            mx = mx + 1;
            if (mx == W) begin
                mx = 0;
                my = (my + 1) % H;
            end
        end
        if (out_valid === 1'b1) pulses++;
        checks++;
        assert (out_valid === exp_v) else begin
            errors++;
            $error("FAIL valid: got %b want %b", out_valid, exp_v);
        end
        if (r) begin
            checks++;
            assert (out_window === '0 && out_x === '0 && out_y === '0) else begin
                errors++;
                $error("FAIL reset_out: win %h x %0d y %0d want zeros",
                       out_window, out_x, out_y);
            end
        end
        if (exp_v) begin
            checks++;
            assert (out_window === exp_w) else begin
                errors++;
                $error("FAIL window: got %h want %h", out_window, exp_w);
            end
            checks++;
            assert (out_x === ex && out_y === ey) else begin
                errors++;
                $error("FAIL coord: got (%0d,%0d) want (%0d,%0d)",
                       out_x, out_y, ex, ey);
            end
            if (plain && ex == 1 && ey == 1) begin
                checks++;
                assert (out_window === 72'h22_21_20_12_11_10_02_01_00) else begin
                    errors++;
                    $error("FAIL first_win: got %h want %h",
                           out_window, 72'h22_21_20_12_11_10_02_01_00);
                end
            end
            if (plain && ex == 1 && ey == 2) begin
                checks++;
                assert (out_window === 72'h32_31_30_22_21_20_12_11_10) else begin
                    errors++;
                    $error("FAIL wrap_win: got %h want %h",
                           out_window, 72'h32_31_30_22_21_20_12_11_10);
                end
            end
        end
    endtask

    // Send pixels [first, last) of a frame in raster order.
    task automatic send(input int base, input bit sof, input int first,
                        input int last, input bit gaps, input bit rnd);
        logic [DW-1:0] d;
        for (int i = first; i < last; i++) begin
            d = rnd ? DW'($urandom) : DW'(base + 16 * (i / W) + (i % W));
            step(1'b1, sof && (i == first), d, 1'b0);
            if (gaps) begin
                step(1'b0, 1'b0, DW'($urandom), 1'b0);
                repeat ($urandom_range(3, 0))
                    step(1'b0, $urandom_range(1, 0) == 1, DW'($urandom), 1'b0);
            end
        end
    endtask

    task automatic expect_pulses(input string tag, input int want);
        checks++;
        assert (pulses === want) else begin
            errors++;
            $error("FAIL %s: got %0d pulses want %0d", tag, pulses, want);
        end
        pulses = 0;
    endtask

    initial begin
        // reset state
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);

        // gapless single frame
        plain  = 1'b1;
        pulses = 0;
        send(0, 1'b1, 0, W * H, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        expect_pulses("gapless", 6);

        // same frame with idle gaps
        send(0, 1'b1, 0, W * H, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        expect_pulses("gaps", 6);

        // back-to-back frames, no sof on the second
        plain = 1'b0;
        send(0, 1'b1, 0, W * H, 1'b0, 1'b0);
        send(8'h80, 1'b0, 0, W * H, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        expect_pulses("b2b", 12);

        // sof in the middle of an old frame at (3,2)
        send(8'h40, 1'b1, 0, 2 * W + 3, 1'b0, 1'b0);
        pulses = 0;
        plain  = 1'b1;
        send(0, 1'b1, 0, W * H, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        expect_pulses("midsof", 6);

        // reset after 8 pixels, with a pixel offered during reset
        plain = 1'b0;
        send(8'h40, 1'b1, 0, 8, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hEE, 1'b1);
        pulses = 0;
        plain  = 1'b1;
        send(0, 1'b0, 0, W * H, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        expect_pulses("after_rst", 6);

        // random pixel values with random gaps
        plain = 1'b0;
        repeat (3) begin
            send(0, 1'b1, 0, W * H, 1'b1, 1'b1);
            step(1'b0, 1'b0, '0, 1'b0);
            expect_pulses("random", 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
